// File: rtl/fpu_arbiter.sv
// Round-robin arbiter that shares one combinational FPU among N_REQ requesters.
// One operation in flight; per-opcode latency is counted down before the result is captured.
module fpu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LAT_DIV = 4,
    parameter int LAT_MUL = 2,
    parameter int LAT_DEF = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [5*N_REQ-1:0]  req_select,
    input  logic [32*N_REQ-1:0] req_data1,
    input  logic [32*N_REQ-1:0] req_data2,
    input  logic [32*N_REQ-1:0] req_data3,
    output logic [N_REQ-1:0]    resp_valid,
    input  logic [N_REQ-1:0]    resp_ready,
    output logic [31:0]         resp_result,
    output logic [4:0]          fpu_select,
    output logic [31:0]         fpu_data1,
    output logic [31:0]         fpu_data2,
    output logic [31:0]         fpu_data3,
    input  logic [31:0]         fpu_result,
    output logic                busy
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = 8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_nxt;
    logic [GW-1:0]  ptr, gnt, gnt_idx;
    logic [CW-1:0]  cnt;
    logic           gnt_any;

    logic [4:0]  sel_a [N_REQ];
    logic [31:0] d1_a  [N_REQ];
    logic [31:0] d2_a  [N_REQ];
    logic [31:0] d3_a  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign sel_a[i] = req_select[5*i +: 5];
        assign d1_a[i]  = req_data1[32*i +: 32];
        assign d2_a[i]  = req_data2[32*i +: 32];
        assign d3_a[i]  = req_data3[32*i +: 32];
    end

    // Counter preload is latency minus one so the last EXEC cycle sees cnt==0.
    function automatic logic [CW-1:0] lat_m1(input logic [4:0] sel);
        if (sel == 5'b00100)
            return CW'(LAT_DIV - 1);
        else if (sel == 5'b00011 || (sel >= 5'b01110 && sel <= 5'b10001))
            return CW'(LAT_MUL - 1);
        else
            return CW'(LAT_DEF - 1);
    endfunction

    // Scan downward so the valid bit closest to ptr is the last (winning) assignment.
    always_comb begin
        logic [GW-1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(ptr) + k) % N_REQ);
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        case (state)
            IDLE: begin
                if (gnt_any && reset_n) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_nxt          = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                resp_valid[gnt] = 1'b1;
                if (resp_ready[gnt]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gnt         <= '0;
            cnt         <= '0;
            fpu_select  <= '0;
            fpu_data1   <= '0;
            fpu_data2   <= '0;
            fpu_data3   <= '0;
            resp_result <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        gnt        <= gnt_idx;
                        fpu_select <= sel_a[gnt_idx];
                        fpu_data1  <= d1_a[gnt_idx];
                        fpu_data2  <= d2_a[gnt_idx];
                        fpu_data3  <= d3_a[gnt_idx];
                        cnt        <= lat_m1(sel_a[gnt_idx]);
                    end
                end
                EXEC: begin
                    if (cnt == '0) resp_result <= fpu_result;
                    else           cnt <= cnt - 1'b1;
                end
                RESP: begin
                    if (resp_ready[gnt])
                        ptr <= (gnt == GW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: timestamp-based transaction model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fpu_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_ready, resp_valid, resp_ready = '1;
    logic [5*N-1:0]  req_select = '0;
    logic [32*N-1:0] req_data1 = '0, req_data2 = '0, req_data3 = '0;
    logic [31:0]     resp_result, fpu_data1, fpu_data2, fpu_data3, fpu_result;
    logic [4:0]      fpu_select;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_select(req_select),
        .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .fpu_select(fpu_select), .fpu_data1(fpu_data1), .fpu_data2(fpu_data2),
        .fpu_data3(fpu_data3), .fpu_result(fpu_result), .busy(busy)
    );

    // Stand-in FPU: exact IEEE results for the directed vectors, a hash otherwise.
    function automatic logic [31:0] fpu_f(input logic [4:0] s, input logic [31:0] a, b, c);
        if (s == 5'b00001 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (s == 5'b00100 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        if (s == 5'b00011 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (s == 5'b01110 && a == 32'h40000000 && b == 32'h40400000 && c == 32'h3F800000)
            return 32'h40E00000;
        return a ^ b ^ c ^ {27'b0, s};
    endfunction

    assign fpu_result = fpu_f(fpu_select, fpu_data1, fpu_data2, fpu_data3);

    function automatic int lat_of(input logic [4:0] s);
        if (s == 5'd4) return 4;
        if (s == 5'd3 || (s >= 5'd14 && s <= 5'd17)) return 2;
        return 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: an op accepted at cycle t answers from cycle t+L+1 until handshake.
    bit          m_busy = 0;
    int          m_ptr = 0, m_own = 0, m_resp = 0;
    logic [4:0]  m_sel = '0;
    logic [31:0] m_d1 = '0, m_d2 = '0, m_d3 = '0, m_res = '0;

    always @(negedge clk) begin
        logic [N-1:0] e_rr, e_rv;
        int g;
        if (!reset_n) begin
            m_busy = 0; m_ptr = 0; m_own = 0; m_sel = '0;
            m_d1 = '0; m_d2 = '0; m_d3 = '0; m_res = '0;
        end
        e_rr = '0;
        e_rv = '0;
        g = -1;
        if (reset_n) begin
            if (!m_busy) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                if (g >= 0) e_rr[g] = 1'b1;
            end else begin
                if (cyc == m_resp) m_res = fpu_f(m_sel, m_d1, m_d2, m_d3);
                if (cyc >= m_resp) e_rv[m_own] = 1'b1;
            end
        end
        chk("m_req_ready", 32'(req_ready), 32'(e_rr));
        chk("m_resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("m_resp_result", resp_result, m_res);
        chk("m_busy", 32'(busy), 32'(m_busy));
        chk("m_fpu_select", 32'(fpu_select), 32'(m_sel));
        chk("m_fpu_data1", fpu_data1, m_d1);
        chk("m_fpu_data2", fpu_data2, m_d2);
        chk("m_fpu_data3", fpu_data3, m_d3);
        if (reset_n) begin
            if (!m_busy && g >= 0) begin
                m_busy = 1; m_own = g;
                m_sel = req_select[g*5 +: 5];
                m_d1 = req_data1[g*32 +: 32];
                m_d2 = req_data2[g*32 +: 32];
                m_d3 = req_data3[g*32 +: 32];
                m_resp = cyc + lat_of(m_sel) + 1;
            end else if (m_busy && cyc >= m_resp && resp_ready[m_own]) begin
                m_busy = 0;
                m_ptr = (m_own + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [4:0] s, input logic [31:0] a, b, c);
        req_select[i*5 +: 5] = s;
        req_data1[i*32 +: 32] = a;
        req_data2[i*32 +: 32] = b;
        req_data3[i*32 +: 32] = c;
    endtask

    task automatic issue(input int i, input logic [4:0] s, input logic [31:0] a, b, c,
                         output int t, output logic [N-1:0] rr);
        set_op(i, s, a, b, c);
        req_valid[i] = 1'b1;
        t = -1;
        rr = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                t = cyc;
                rr = req_ready;
                break;
            end
        end
        if (t < 0) chk("accept_timeout", 32'(req_ready), 32'(1 << i));
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(input int i, output int tr);
        tr = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (resp_valid[i]) begin
                tr = cyc;
                break;
            end
        end
        if (tr < 0) chk("resp_timeout", 32'(resp_valid), 32'(1 << i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tr, n;
        int order [5];
        logic [N-1:0] rr;
        logic [31:0] held;

        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // FADD from requester 0
        issue(0, 5'b00001, 32'h3F800000, 32'h40000000, 32'h0, t, rr);
        chk("fadd_ready", 32'(rr), 32'h1);
        wait_resp(0, tr);
        chk("fadd_lat", 32'(tr - t), 32'd2);
        chk("fadd_valid", 32'(resp_valid), 32'h1);
        chk("fadd_result", resp_result, 32'h40400000);
        tick();

        // FMADD from requester 1
        issue(1, 5'b01110, 32'h40000000, 32'h40400000, 32'h3F800000, t, rr);
        chk("fmadd_ready", 32'(rr), 32'h2);
        wait_resp(1, tr);
        chk("fmadd_lat", 32'(tr - t), 32'd3);
        chk("fmadd_result", resp_result, 32'h40E00000);
        tick();

        // FDIV from requester 2: operands held through all execute cycles
        issue(2, 5'b00100, 32'h40C00000, 32'h40000000, 32'h0, t, rr);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fdiv_data1", fpu_data1, 32'h40C00000);
            chk("fdiv_data2", fpu_data2, 32'h40000000);
            chk("fdiv_busy", 32'(busy), 32'd1);
        end
        wait_resp(2, tr);
        chk("fdiv_lat", 32'(tr - t), 32'd5);
        chk("fdiv_valid", 32'(resp_valid), 32'h4);
        chk("fdiv_result", resp_result, 32'h40400000);
        tick();

        // Reset during FDIV execute, then requester 3 alone
        issue(0, 5'b00100, 32'h40C00000, 32'h40000000, 32'h0, t, rr);
        chk("rdiv_ready", 32'(rr), 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_fpu_select", 32'(fpu_select), 32'd0);
        chk("arst_fpu_data1", fpu_data1, 32'd0);
        chk("arst_fpu_data2", fpu_data2, 32'd0);
        chk("arst_resp_result", resp_result, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        issue(3, 5'b00001, 32'h11111111, 32'h22222222, 32'h0, t, rr);
        chk("post_rst_ready", 32'(rr), 32'h8);
        wait_resp(3, tr);
        chk("post_rst_lat", 32'(tr - t), 32'd2);
        chk("post_rst_result", resp_result, 32'h33333332);
        tick();

        // All four continuously valid: fair rotation from ptr 0
        for (int i = 0; i < N; i++) set_op(i, 5'b00001, 32'(i + 1), 32'h100, 32'h0);
        req_valid = '1;
        n = 0;
        for (int k = 0; k < 200 && n < 5; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int j = 0; j < N; j++) if (req_ready[j]) order[n] = j;
                n++;
                if (n == 5) begin
                    tick();
                    req_valid = '0;
                end
            end
        end
        chk("rr_count", 32'(n), 32'd5);
        chk("rr_g0", 32'(order[0]), 32'd0);
        chk("rr_g1", 32'(order[1]), 32'd1);
        chk("rr_g2", 32'(order[2]), 32'd2);
        chk("rr_g3", 32'(order[3]), 32'd3);
        chk("rr_g4", 32'(order[4]), 32'd0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("rr_drain", 32'(busy), 32'd0);
        tick();

        // FMUL with requester 1 stalling the response; others' ready bits ignored
        resp_ready = 4'b1101;
        issue(1, 5'b00011, 32'h40000000, 32'h40400000, 32'h0, t, rr);
        chk("fmul_ready", 32'(rr), 32'h2);
        wait_resp(1, tr);
        chk("fmul_lat", 32'(tr - t), 32'd3);
        chk("fmul_result", resp_result, 32'h40C00000);
        held = resp_result;
        tick();
        set_op(0, 5'b11111, 32'h0000000F, 32'h000000F0, 32'h00000F00);
        req_valid[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(resp_valid), 32'h2);
            chk("stall_result", resp_result, held);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        tick();
        resp_ready = '1;
        @(negedge clk);
        chk("hs_valid", 32'(resp_valid), 32'h2);
        chk("hs_req_ready", 32'(req_ready), 32'd0);
        tick();

        // Requester 0 wins after wrap; opcode above 5'b10100 uses default latency
        @(negedge clk);
        chk("wrap_ready", 32'(req_ready), 32'h1);
        t = cyc;
        tick();
        req_valid[0] = 1'b0;
        wait_resp(0, tr);
        chk("hisel_lat", 32'(tr - t), 32'd2);
        chk("hisel_result", resp_result, 32'h00000FE0);
        tick();

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001: Parameter N_REQ, default 4, SHALL set the number of requesters sharing the FPU (2..8).
REQ-002: Parameter LAT_DIV, default 4, SHALL set the execute cycles allowed for SELECT 5'b00100 (FDIV).
REQ-003: Parameter LAT_MUL, default 2, SHALL set the execute cycles for SELECT 5'b00011 (FMUL) and 5'b01110..5'b10001 (fused multiply-add family).
REQ-004: Parameter LAT_DEF, default 1, SHALL set the execute cycles for every other SELECT value.
REQ-005: CLK  in  1  the single clock; all state changes on its rising edge.
REQ-006: RESET_N  in  1  asynchronous, active-low reset.
REQ-007: REQ_VALID  in  N_REQ  per-requester operation valid.
REQ-008: REQ_READY  out  N_REQ  per-requester accept strobe, one-hot or zero.
REQ-009: REQ_SELECT  in  5*N_REQ  per-requester FPU opcode; requester i occupies bits [5i+4:5i].
REQ-010: REQ_DATA1, REQ_DATA2, REQ_DATA3  in  32*N_REQ each  per-requester operands; requester i occupies bits [32i+31:32i].
REQ-011: RESP_VALID  out  N_REQ  one-hot result-valid to the owning requester.
REQ-012: RESP_READY  in  N_REQ  per-requester result accept.
REQ-013: RESP_RESULT  out  32  registered FPU result, shared by all requesters.
REQ-014: FPU_SELECT  out  5  and FPU_DATA1/2/3  out  32 each  registered operands driven to the FPU.
REQ-015: FPU_RESULT  in  32  combinational RESULT returned by the FPU.
REQ-016: BUSY  out  1  high in any state other than IDLE.

Function
REQ-017: The controller SHALL implement three states: IDLE, EXEC, RESP.
REQ-018: In IDLE, when any REQ_VALID bit is set, the controller SHALL grant the first set bit at or after the round-robin pointer PTR, wrapping from N_REQ-1 to 0.
REQ-019: REQ_READY[g] SHALL be asserted combinationally in IDLE for the granted requester only; a request is accepted when REQ_VALID[g] and REQ_READY[g] are both high.
REQ-020: On acceptance, the controller SHALL register SELECT and DATA1..3 of requester g into FPU_SELECT/FPU_DATA1..3, record the grant index g, load CNT with L-1 (L is the latency for that SELECT), and move to EXEC.
REQ-021: FPU_* outputs SHALL hold constant from acceptance until the next acceptance.
REQ-022: In EXEC, CNT SHALL decrement each cycle; in the cycle CNT==0, FPU_RESULT SHALL be captured into RESP_RESULT and the state SHALL move to RESP.
REQ-023: Latency: acceptance in cycle t gives RESP_VALID high from cycle t+L+1.
REQ-024: In RESP, RESP_VALID[g] SHALL be high and RESP_RESULT stable until RESP_READY[g] is sampled high; RESP_READY bits of other requesters SHALL be ignored.
REQ-025: On the response handshake, PTR SHALL become (g+1) mod N_REQ and the state SHALL return to IDLE; a new grant SHALL occur no earlier than the following cycle.
REQ-026: PTR SHALL change only on response handshakes, and only one operation SHALL be in flight at any time.
REQ-027: SELECT values above 5'b10100 SHALL use LAT_DEF and return whatever FPU_RESULT presents; no error is flagged.
REQ-028: REQ_VALID changes while in EXEC or RESP SHALL NOT affect the in-flight operation.

Reset
REQ-029: While RESET_N is low, the block SHALL be in IDLE, with PTR=0, CNT=0, grant index 0, FPU_SELECT=0, FPU_DATA1..3=0, RESP_RESULT=0, RESP_VALID=0, REQ_READY=0 and BUSY=0, independent of CLK.
REQ-030: Reset asserted mid-operation SHALL abandon the operation with no response; after release, the first grant SHALL follow REQ-018 with PTR=0.

Verification
REQ-031: Requester 0 issues FADD (5'b00001) with 3F800000 + 40000000, RESP_READY tied high -> REQ_READY[0] high in acceptance cycle t, RESP_VALID=4'b0001 at t+2, RESP_RESULT=40400000.
REQ-032: Requester 2 issues FDIV 40C00000 / 40000000 -> FPU_DATA1/2 stable for 4 cycles, RESP_VALID[2] at t+5, RESP_RESULT=40400000.
REQ-033: All four requesters hold REQ_VALID continuously -> grants in order 0,1,2,3,0, and no requester is granted twice before every other valid requester has been granted.
REQ-034: RESP_READY[1] held low for 6 cycles during a FMUL response -> RESP_VALID[1] and RESP_RESULT stay constant, REQ_READY stays 0, and BUSY stays 1 until the handshake.
REQ-035: RESET_N pulled low during EXEC of an FDIV -> all outputs are 0 immediately; after release, requester 3 alone valid is granted and completes normally.
REQ-036: Requester 1 issues FMADD (5'b01110) 40000000*40400000+3F800000 -> RESP_VALID[1] at t+3, RESP_RESULT=40E00000.
